// File: rtl/adc_hyst_comp.sv
// Periodic ADC sampler with window averaging and a hysteresis comparator.
// Optional ADC_RUNTIME_THRESH_EN replaces THRESH/HYST with shadowed runtime inputs.
module adc_hyst_comp #(
   parameter int               ADC_W    = 12,
   parameter int               PERIOD   = 200,
   parameter int               AVG_LOG2 = 2,
   parameter logic [ADC_W-1:0] THRESH   = ADC_W'(12'h800),
   parameter logic [ADC_W-1:0] HYST     = ADC_W'(12'h000)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             swiptAlive,
   input  logic [ADC_W-1:0] ADC,
`ifdef ADC_RUNTIME_THRESH_EN
   input  logic [ADC_W-1:0] thresh_in,
   input  logic [ADC_W-1:0] hyst_in,
`endif
   output logic             ADC_comp,
   output logic             comp_valid,
   output logic [ADC_W-1:0] adc_mean,
   output logic             sample_tick
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int NS    = 1 << AVG_LOG2;
   localparam int CNT_W = $clog2(PERIOD);
   localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   typedef enum logic {ST_ACCUM, ST_DECIDE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_acc;
   logic [N_W-1:0]     r_n;
   logic               r_decided;
   logic [ADC_W-1:0]   w_thr;
   logic [ADC_W-1:0]   w_hys;
   logic               w_tick;
   logic               w_last;
   logic [ADC_W-1:0]   w_mean_nxt;
   logic [ADC_W:0]     w_mean_x;
   logic [ADC_W:0]     w_lo;
   logic [ADC_W:0]     w_hi;
   logic               w_lo_ok;
   logic               w_comp_nxt;
   logic               w_clear;

`ifdef ADC_RUNTIME_THRESH_EN
   logic [ADC_W-1:0]   r_thr;
   logic [ADC_W-1:0]   r_hys;
   assign w_thr = r_thr;
   assign w_hys = r_hys;
`else
   assign w_thr = THRESH;
   assign w_hys = HYST;
`endif

   assign w_clear    = ~nrst | ~swiptAlive;
   assign w_tick     = (r_cnt == '0);
   assign w_last     = w_tick && (r_n == N_W'(NS - 1));
   assign w_mean_nxt = r_acc[ACC_W-1:AVG_LOG2];

   // Band edges are one bit wider so hi never wraps; lo is only usable when THRESH >= HYST.
   assign w_mean_x = {1'b0, w_mean_nxt};
   assign w_lo_ok  = (w_thr >= w_hys);
   assign w_lo     = {1'b0, w_thr} - {1'b0, w_hys};
   assign w_hi     = {1'b0, w_thr} + {1'b0, w_hys};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_comp_nxt  = ADC_comp;
      case (r_state)
         ST_ACCUM:  if (w_last) w_state_nxt = ST_DECIDE;
         ST_DECIDE: w_state_nxt = ST_ACCUM;
         default:   w_state_nxt = ST_ACCUM;
      endcase
      if (!ADC_comp && w_lo_ok && (w_mean_x < w_lo))
         w_comp_nxt = 1'b1;
      else if (ADC_comp && (w_mean_x >= w_hi))
         w_comp_nxt = 1'b0;
   end

   // NOTE: state uses non-blocking assignments; clear is sampled only at the clock edge.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_state     <= ST_ACCUM;
         r_cnt       <= CNT_W'(PERIOD - 1);
         r_acc       <= '0;
         r_n         <= '0;
         r_decided   <= 1'b0;
         ADC_comp    <= 1'b0;
         comp_valid  <= 1'b0;
         adc_mean    <= '0;
         sample_tick <= 1'b0;
`ifdef ADC_RUNTIME_THRESH_EN
         r_thr       <= THRESH;
         r_hys       <= HYST;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_tick ? CNT_W'(PERIOD - 1) : r_cnt - 1'b1;
         sample_tick <= w_tick;
         r_decided   <= (r_state == ST_DECIDE);
         comp_valid  <= r_decided;
         if (r_state == ST_ACCUM && w_tick) begin
            r_acc <= r_acc + ACC_W'(ADC);
            r_n   <= r_n + 1'b1;
         end
         if (r_state == ST_DECIDE) begin
            adc_mean <= w_mean_nxt;
            ADC_comp <= w_comp_nxt;
            r_acc    <= '0;
            r_n      <= '0;
`ifdef ADC_RUNTIME_THRESH_EN
            // Decision above used the old shadow values; new ones apply to the next window.
            r_thr    <= thresh_in;
            r_hys    <= hyst_in;
`endif
         end
      end
   end

endmodule

// File: tb/tb_adc_hyst_comp.sv
// Self-checking bench: four adc_hyst_comp configurations against a cycle-count model.
module tb_adc_hyst_comp;

   logic        clk = 1'b0;
   logic        nrst;
   logic        swiptAlive;
   logic [11:0] adc     [4];
   logic        d_comp  [4];
   logic        d_valid [4];
   logic        d_tick  [4];
   logic [11:0] d_mean  [4];

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;
   int rel_k    = -1;
   int rel_cnt  = 0;

   localparam int PER = 4;

   always #5 clk = ~clk;

   // u_a: hysteresis 0x800/0x40, u_b: 4-sample average, u_c: HYST > THRESH, u_d: plain compare
   adc_hyst_comp #(.ADC_W(12), .PERIOD(PER), .AVG_LOG2(0), .THRESH(12'h800), .HYST(12'h040)) u_a (
      .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .ADC(adc[0]),
      .ADC_comp(d_comp[0]), .comp_valid(d_valid[0]), .adc_mean(d_mean[0]), .sample_tick(d_tick[0]));
   adc_hyst_comp #(.ADC_W(12), .PERIOD(PER), .AVG_LOG2(2), .THRESH(12'h800), .HYST(12'h000)) u_b (
      .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .ADC(adc[1]),
      .ADC_comp(d_comp[1]), .comp_valid(d_valid[1]), .adc_mean(d_mean[1]), .sample_tick(d_tick[1]));
   adc_hyst_comp #(.ADC_W(12), .PERIOD(PER), .AVG_LOG2(0), .THRESH(12'h010), .HYST(12'h020)) u_c (
      .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .ADC(adc[2]),
      .ADC_comp(d_comp[2]), .comp_valid(d_valid[2]), .adc_mean(d_mean[2]), .sample_tick(d_tick[2]));
   adc_hyst_comp #(.ADC_W(12), .PERIOD(PER), .AVG_LOG2(0), .THRESH(12'h800), .HYST(12'h000)) u_d (
      .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .ADC(adc[3]),
      .ADC_comp(d_comp[3]), .comp_valid(d_valid[3]), .adc_mean(d_mean[3]), .sample_tick(d_tick[3]));

   function automatic int ns_of(input int i);
      return (i == 1) ? 4 : 1;
   endfunction
   function automatic int thr_of(input int i);
      return (i == 2) ? 'h010 : 'h800;
   endfunction
   function automatic int hys_of(input int i);
      return (i == 0) ? 'h040 : ((i == 2) ? 'h020 : 0);
   endfunction

   task automatic check(input string name, input int inst, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   // Behavioural model: edge k=0 is the first unclear edge; ticks act at k = PER-1 + m*PER.
   int m_k [4], m_n [4], m_sum [4], m_dec [4], m_vat [4], m_mean [4];
   bit m_comp [4], m_valid [4], m_tick [4];

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!nrst || !swiptAlive) begin
               m_k[i] = -1; m_n[i] = 0; m_sum[i] = 0; m_dec[i] = -10; m_vat[i] = -10;
               m_mean[i] = 0; m_comp[i] = 0; m_valid[i] = 0; m_tick[i] = 0;
            end else begin
               m_k[i]++;
               m_tick[i]  = (m_k[i] >= PER - 1) && ((m_k[i] - (PER - 1)) % PER == 0);
               m_valid[i] = (m_k[i] == m_vat[i]);
               if (m_k[i] == m_dec[i]) begin
                  m_mean[i] = m_sum[i] / ns_of(i);
                  if (!m_comp[i] && thr_of(i) >= hys_of(i) && m_mean[i] < thr_of(i) - hys_of(i))
                     m_comp[i] = 1'b1;
                  else if (m_comp[i] && m_mean[i] >= thr_of(i) + hys_of(i))
                     m_comp[i] = 1'b0;
                  m_sum[i] = 0;
                  m_n[i]   = 0;
                  m_vat[i] = m_k[i] + 1;
               end
               if (m_tick[i]) begin
                  m_sum[i] += int'(adc[i]);
                  m_n[i]++;
                  if (m_n[i] == ns_of(i)) m_dec[i] = m_k[i] + 1;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      started <= 1'b1;
      if (!nrst || !swiptAlive) rel_k <= -1;
      else begin
         if (rel_k == -1) rel_cnt <= rel_cnt + 1;
         rel_k <= rel_k + 1;
      end
   end

   // Compare process: model on every cycle, plus hand-computed literals at known points.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 4; i++) begin
            check("comp",  i, int'(d_comp[i]),  int'(m_comp[i]));
            check("valid", i, int'(d_valid[i]), int'(m_valid[i]));
            check("mean",  i, int'(d_mean[i]),  m_mean[i]);
            check("tick",  i, int'(d_tick[i]),  int'(m_tick[i]));
         end
         if (rel_cnt == 0) begin
            check("clr_comp",  3, int'(d_comp[3]),  0);
            check("clr_valid", 3, int'(d_valid[3]), 0);
            check("clr_mean",  3, int'(d_mean[3]),  0);
            check("clr_tick",  3, int'(d_tick[3]),  0);
         end
         if (rel_cnt == 1) begin
            case (rel_k)
               2:  check("lit_tick_k2", 3, int'(d_tick[3]), 0);
               3:  check("lit_tick_k3", 3, int'(d_tick[3]), 1);
               4: begin
                  check("lit_valid_k4", 3, int'(d_valid[3]), 0);
                  check("lit_mean_k4",  3, int'(d_mean[3]),  'h7FF);
               end
               5: begin
                  check("lit_valid_k5", 3, int'(d_valid[3]), 1);
                  check("lit_comp_k5",  3, int'(d_comp[3]),  1);
                  check("lit_mean_k5",  3, int'(d_mean[3]),  'h7FF);
                  check("lit_hcomp_k5", 0, int'(d_comp[0]),  0);
                  check("lit_hmean_k5", 0, int'(d_mean[0]),  'h7D0);
                  check("lit_ecomp_k5", 2, int'(d_comp[2]),  0);
               end
               9: begin
                  check("lit_comp_k9",  3, int'(d_comp[3]), 0);
                  check("lit_mean_k9",  3, int'(d_mean[3]), 'h800);
                  check("lit_hcomp_k9", 0, int'(d_comp[0]), 1);
               end
               13: begin
                  check("lit_hcomp_k13", 0, int'(d_comp[0]), 1);
                  check("lit_hmean_k13", 0, int'(d_mean[0]), 'h83F);
                  check("lit_ecomp_k13", 2, int'(d_comp[2]), 0);
                  check("lit_emean_k13", 2, int'(d_mean[2]), 'h005);
               end
               16: check("lit_avalid_k16", 1, int'(d_valid[1]), 0);
               17: begin
                  check("lit_avalid_k17", 1, int'(d_valid[1]), 1);
                  check("lit_amean_k17",  1, int'(d_mean[1]),  'h7FF);
                  check("lit_acomp_k17",  1, int'(d_comp[1]),  1);
                  check("lit_hcomp_k17",  0, int'(d_comp[0]),  0);
                  check("lit_hmean_k17",  0, int'(d_mean[0]),  'h840);
               end
               default: ;
            endcase
            if (rel_k > 17) check("lit_novalid_partial", 1, int'(d_valid[1]), 0);
         end
         if (rel_cnt == 2) begin
            if (rel_k == 0) begin
               check("lit_comp_after_clr", 1, int'(d_comp[1]), 0);
               check("lit_mean_after_clr", 1, int'(d_mean[1]), 0);
            end
            if (rel_k == 17) begin
               check("lit_fresh_valid", 1, int'(d_valid[1]), 1);
               check("lit_fresh_mean",  1, int'(d_mean[1]),  'h7F0);
               check("lit_fresh_comp",  1, int'(d_comp[1]),  1);
            end
         end
      end
   end

   // One sample period: random ADC between ticks, the given values in the tick cycle.
   task automatic tick_sample(input logic [11:0] va, input logic [11:0] vb,
                              input logic [11:0] vc, input logic [11:0] vd);
      repeat (PER - 1) begin
         for (int i = 0; i < 4; i++) adc[i] = 12'($urandom);
         @(negedge clk);
      end
      adc[0] = va; adc[1] = vb; adc[2] = vc; adc[3] = vd;
      @(negedge clk);
   endtask

   initial begin
      nrst = 1'b0;
      swiptAlive = 1'b1;
      for (int i = 0; i < 4; i++) adc[i] = 12'hFFF;
      repeat (5) @(negedge clk);
      nrst = 1'b1;
      swiptAlive = 1'b0;
      repeat (5) @(negedge clk);
      swiptAlive = 1'b1;

      tick_sample(12'h7D0, 12'h700, 12'h000, 12'h7FF);
      tick_sample(12'h7BF, 12'h900, 12'h000, 12'h800);
      tick_sample(12'h83F, 12'h800, 12'h005, 12'h7FF);
      tick_sample(12'h840, 12'h7FC, 12'h00F, 12'h800);
      tick_sample(12'h7FF, 12'h100, 12'h000, 12'h7FF);
      tick_sample(12'h7FF, 12'h100, 12'h000, 12'h7FF);

      swiptAlive = 1'b0;
      @(negedge clk);
      swiptAlive = 1'b1;

      tick_sample(12'h7B0, 12'h7F0, 12'h000, 12'h900);
      tick_sample(12'h7B0, 12'h7F0, 12'h000, 12'h100);
      tick_sample(12'h850, 12'h7F0, 12'h000, 12'h900);
      tick_sample(12'h850, 12'h7F0, 12'h000, 12'h100);
      repeat (5) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
